ft600_bus_responder: RTL and testbench
======================================

Name: ft600_bus_responder

Overview:
- Synthesizable, single-clock model of the FT600 chip side of the 245-synchronous FIFO bus.
- Drives rxf_n/txe_n, answers rd_n/oe_n/wr_n from the FPGA-side bus master, and buffers words in both directions.
- Used for on-FPGA loopback and for simulation benches of the FPGA-side FSM.
- A host-side valid/ready stream stands in for USB: it injects words to be read by the master and drains words written by the master.

Parameters:
- FT_DATA_WIDTH, 32, width of ft_data and of the stream data ports.
- DEPTH, 1024, words per direction buffer (4 kB); power of two.
- THROTTLE_BURST, 256, words per burst before a forced flag gap (optional feature only).
- THROTTLE_GAP, 8, clk cycles flags stay deasserted after a burst (optional feature only).

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rxf_n  out  1  low = read buffer non-empty, master may read.
- txe_n  out  1  low = write buffer has space, master may write.
- rd_n  in  1  master read strobe.
- oe_n  in  1  master output enable; responder drives the bus while low.
- wr_n  in  1  master write strobe.
- ft_data  inout  FT_DATA_WIDTH  bidirectional bus.
- ft_be  inout  4  byte enables.
- h2f_data  in  FT_DATA_WIDTH  word pushed into the read buffer.
- h2f_valid  in  1  push request.
- h2f_ready  out  1  read buffer not full.
- f2h_data  out  FT_DATA_WIDTH  head of the write buffer.
- f2h_be  out  4  byte enables captured with f2h_data.
- f2h_valid  out  1  write buffer non-empty.
- f2h_ready  in  1  pop acknowledge.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous, active-high): both buffers emptied, FSM set to IDLE.
  - rxf_n=1, txe_n=1, proto_err=0, h2f_ready=0, f2h_valid=0.
  - ft_data and ft_be high-Z.
  - Reset mid-burst discards all buffered words.
- Bus drive:
  - ft_data is driven with the read-buffer head iff oe_n==0; otherwise high-Z.
  - ft_be is driven 4'b1111 iff oe_n==0; otherwise high-Z.
- Flags are registered and updated from the next-state buffer counts:
  - rxf_n = (rd_count_next == 0).
  - txe_n = (wr_count_next == DEPTH).
- FSM states:
  - IDLE:
    - oe_n==0 -> RD_TURN.
    - wr_n==0 -> WR_XFER, and the same edge captures.
    - Otherwise stay in IDLE.
  - RD_TURN (bus turnaround, data driven, no pop):
    - rd_n==0 -> RD_XFER, and the same edge pops.
    - oe_n==1 -> IDLE.
  - RD_XFER:
    - Each edge with rd_n==0, oe_n==0 and rd_count>0 pops one word; the next head appears the following cycle.
    - oe_n==1 -> IDLE.
  - WR_XFER:
    - Each edge with wr_n==0 and wr_count<DEPTH captures {ft_be, ft_data}.
    - wr_n==1 -> IDLE.
- Protocol violations (each sets proto_err; it stays set until reset):
  - wr_n==0 with oe_n==0 on the same edge; no capture, no pop.
  - rd_n==0 with rxf_n==1; no pop.
  - wr_n==0 with txe_n==1; word dropped.
- Host side:
  - A push occurs on an edge with h2f_valid & h2f_ready.
  - A pop occurs on an edge with f2h_valid & f2h_ready.
  - A push and a bus pop on the same edge both succeed and the count is unchanged; the same holds for a bus capture plus a host pop.
- Boundaries:
  - Last word popped -> rxf_n=1 in the following cycle.
  - Write buffer reaches DEPTH -> txe_n=1 in the following cycle.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: FT600_RESPONDER_THROTTLE_EN.
- With the macro defined:
  - A transfer counter increments per bus pop or capture.
  - When it reaches THROTTLE_BURST, rxf_n and txe_n are forced to 1 for THROTTLE_GAP cycles, then the counter clears.
  - This emulates USB packet boundaries.
- Without the macro: flags depend only on buffer levels; no counter logic is present.

Decomposition:
- Package ft600_pkg holds:
  - FSM state encoding (IDLE, RD_TURN, RD_XFER, WR_XFER), one-hot.
  - FT_BE_WIDTH=4 and FT_BE_ALL=4'b1111.
- Sub-module ft600_sync_fifo: single-clock, first-word-fall-through, parameterised width/depth, exposing count.
  - Instantiated twice: read buffer width FT_DATA_WIDTH; write buffer width FT_DATA_WIDTH+4.

Test Plan:
1. Reset held 3 cycles, then released -> rxf_n=1, txe_n=0, ft_data high-Z, proto_err=0.
2. Push 0x00000001..0x00000004, then master does oe_n low, rd_n low for 4 cycles -> bus shows 1,2,3,4 in order, then rxf_n=1.
3. Master writes 0xA5A5A5A5, 0x5A5A5A5A with be=4'b1111 -> f2h_data delivers both in order with f2h_be=4'hF.
4. Fill write buffer with 1024 words and hold f2h_ready=0 -> txe_n=1; a 1025th write strobe sets proto_err=1 and the word is dropped.
5. Drive wr_n=0 and oe_n=0 on the same edge -> proto_err=1, both counts unchanged.
6. FT600_RESPONDER_THROTTLE_EN with THROTTLE_BURST=4, THROTTLE_GAP=3 and 8 words queued -> rxf_n high for exactly 3 cycles after the 4th pop.

Source files
------------

// File: rtl/ft600_pkg.sv
// ============================================================================
// ft600_pkg : shared FSM encoding and byte-enable constants for the FT600 responder
// Rev 1.0
// ============================================================================
`default_nettype none

package ft600_pkg;

    localparam int                      FT_BE_WIDTH = 4;
    localparam logic [FT_BE_WIDTH-1:0]  FT_BE_ALL   = 4'b1111;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        RD_TURN = 4'b0010,
        RD_XFER = 4'b0100,
        WR_XFER = 4'b1000
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ft600_sync_fifo.sv
// ============================================================================
// ft600_sync_fifo : single-clock first-word-fall-through FIFO with occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module ft600_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && (r_count != c_depth);
    assign w_pop  = pop && (r_count != '0);
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/ft600_bus_responder.sv
// ============================================================================
// ft600_bus_responder : FT600-side model of the 245 synchronous FIFO bus.
// Optional USB packet-gap emulation: define FT600_RESPONDER_THROTTLE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ft600_bus_responder
    import ft600_pkg::*;
#(
    parameter int FT_DATA_WIDTH  = 32,
    parameter int DEPTH          = 1024,
    parameter int THROTTLE_BURST = 256,
    parameter int THROTTLE_GAP   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      rxf_n,
    output logic                      txe_n,
    input  logic                      rd_n,
    input  logic                      oe_n,
    input  logic                      wr_n,
    inout  wire  [FT_DATA_WIDTH-1:0]  ft_data,
    inout  wire  [FT_BE_WIDTH-1:0]    ft_be,
    input  logic [FT_DATA_WIDTH-1:0]  h2f_data,
    input  logic                      h2f_valid,
    output logic                      h2f_ready,
    output logic [FT_DATA_WIDTH-1:0]  f2h_data,
    output logic [FT_BE_WIDTH-1:0]    f2h_be,
    output logic                      f2h_valid,
    input  logic                      f2h_ready,
    output logic                      proto_err
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            WW      = FT_DATA_WIDTH + FT_BE_WIDTH;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    state_t                   r_state;
    logic [CW-1:0]            w_rd_count;
    logic [CW-1:0]            w_wr_count;
    logic [CW-1:0]            w_rd_count_next;
    logic [CW-1:0]            w_wr_count_next;
    logic [FT_DATA_WIDTH-1:0] w_rd_head;
    logic [WW-1:0]            w_wr_head;
    logic                     w_in_rd;
    logic                     w_in_wr;
    logic                     w_bus_pop;
    logic                     w_bus_cap;
    logic                     w_h2f_push;
    logic                     w_f2h_pop;
    logic                     w_violation;
    logic                     w_force;

    assign w_in_rd    = (r_state == RD_TURN) || (r_state == RD_XFER);
    assign w_in_wr    = (r_state == IDLE) || (r_state == WR_XFER);
    assign w_bus_pop  = w_in_rd && !rd_n && !oe_n && wr_n && !rxf_n && (w_rd_count != '0);
    assign w_bus_cap  = w_in_wr && !wr_n && oe_n && !txe_n && (w_wr_count != c_depth);
    assign w_h2f_push = h2f_valid && h2f_ready;
    assign w_f2h_pop  = f2h_valid && f2h_ready;

    assign w_rd_count_next = w_rd_count + CW'(w_h2f_push) - CW'(w_bus_pop);
    assign w_wr_count_next = w_wr_count + CW'(w_bus_cap) - CW'(w_f2h_pop);

    assign w_violation = (!wr_n && !oe_n) || (!rd_n && rxf_n) || (!wr_n && txe_n);

    assign ft_data  = oe_n ? {FT_DATA_WIDTH{1'bz}} : w_rd_head;
    assign ft_be    = oe_n ? {FT_BE_WIDTH{1'bz}} : FT_BE_ALL;
    assign f2h_data = w_wr_head[FT_DATA_WIDTH-1:0];
    assign f2h_be   = w_wr_head[WW-1:FT_DATA_WIDTH];

    ft600_sync_fifo #(.WIDTH(FT_DATA_WIDTH), .DEPTH(DEPTH)) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_h2f_push),
        .push_data (h2f_data),
        .pop       (w_bus_pop),
        .head      (w_rd_head),
        .count     (w_rd_count)
    );

    ft600_sync_fifo #(.WIDTH(WW), .DEPTH(DEPTH)) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_bus_cap),
        .push_data ({ft_be, ft_data}),
        .pop       (w_f2h_pop),
        .head      (w_wr_head),
        .count     (w_wr_count)
    );

`ifdef FT600_RESPONDER_THROTTLE_EN
    localparam int            TW         = $clog2(THROTTLE_BURST + 1);
    localparam int            GW         = $clog2(THROTTLE_GAP + 1);
    localparam logic [TW-1:0] c_burst    = TW'(THROTTLE_BURST);
    localparam logic [GW-1:0] c_gap_last = GW'(THROTTLE_GAP - 1);

    logic [TW-1:0] r_xfer_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [TW-1:0] w_xfer_next;
    logic          w_gap_done;

    // Forced flags also block transfers, so the counter holds at the burst
    // value for the whole gap and only the gap counter advances.
    assign w_xfer_next = r_xfer_cnt + TW'(w_bus_pop || w_bus_cap);
    assign w_gap_done  = (r_xfer_cnt == c_burst) && (r_gap_cnt == c_gap_last);
    assign w_force     = (w_xfer_next == c_burst) && !w_gap_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_cnt <= '0;
            r_gap_cnt  <= '0;
        end else if (r_xfer_cnt == c_burst) begin
            if (w_gap_done) begin
                r_xfer_cnt <= '0;
                r_gap_cnt  <= '0;
            end else begin
                r_gap_cnt  <= r_gap_cnt + GW'(1);
            end
        end else begin
            r_xfer_cnt <= w_xfer_next;
        end
    end
`else
    logic w_unused_throttle;
    assign w_unused_throttle = (THROTTLE_BURST != 0) ^ (THROTTLE_GAP != 0);
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            rxf_n     <= 1'b1;
            txe_n     <= 1'b1;
            h2f_ready <= 1'b0;
            f2h_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rxf_n     <= w_force || (w_rd_count_next == '0);
            txe_n     <= w_force || (w_wr_count_next == c_depth);
            h2f_ready <= (w_rd_count_next != c_depth);
            f2h_valid <= (w_wr_count_next != '0);
            if (w_violation) proto_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (!oe_n)      r_state <= RD_TURN;
                    else if (!wr_n) r_state <= WR_XFER;
                end
                RD_TURN: begin
                    if (oe_n)       r_state <= IDLE;
                    else if (!rd_n) r_state <= RD_XFER;
                end
                RD_XFER: begin
                    if (oe_n)       r_state <= IDLE;
                end
                WR_XFER: begin
                    if (wr_n)       r_state <= IDLE;
                end
                default:            r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ft600_bus_responder.sv
// ============================================================================
// tb_ft600_bus_responder : directed vector bench for ft600_bus_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ft600_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_n, oe_n, wr_n;
    logic        h2f_valid, f2h_ready;
    logic [31:0] h2f_data;
    logic [31:0] tb_data;
    logic [3:0]  tb_be;
    logic        tb_drv;
    wire  [31:0] ft_data;
    wire  [3:0]  ft_be;
    logic        rxf_n, txe_n, h2f_ready, f2h_valid, proto_err;
    logic [31:0] f2h_data;
    logic [3:0]  f2h_be;

    int tests = 0;
    int fails = 0;

    assign ft_data = tb_drv ? tb_data : 32'hzzzz_zzzz;
    assign ft_be   = tb_drv ? tb_be : 4'hz;

    always #5 clk = ~clk;

    ft600_bus_responder #(
        .FT_DATA_WIDTH  (32),
        .DEPTH          (1024),
        .THROTTLE_BURST (4),
        .THROTTLE_GAP   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxf_n     (rxf_n),
        .txe_n     (txe_n),
        .rd_n      (rd_n),
        .oe_n      (oe_n),
        .wr_n      (wr_n),
        .ft_data   (ft_data),
        .ft_be     (ft_be),
        .h2f_data  (h2f_data),
        .h2f_valid (h2f_valid),
        .h2f_ready (h2f_ready),
        .f2h_data  (f2h_data),
        .f2h_be    (f2h_be),
        .f2h_valid (f2h_valid),
        .f2h_ready (f2h_ready),
        .proto_err (proto_err)
    );

    typedef struct {
        logic        oe_n, rd_n, wr_n, hv, fr;
        logic [31:0] hd, wd;
        logic        exp_rxf, exp_txe, exp_fv;
        logic        chk_bus;
        logic [31:0] exp_bus;
        logic        chk_f2h;
        logic [31:0] exp_f2h;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(logic oe, logic rd, logic wr, logic hv, logic [31:0] hd,
                                logic fr, logic [31:0] wd, logic rxf, logic txe, logic fv,
                                logic cb, logic [31:0] eb, logic cf, logic [31:0] ef);
        vec_t v;
        v.oe_n = oe; v.rd_n = rd; v.wr_n = wr; v.hv = hv; v.hd = hd; v.fr = fr; v.wd = wd;
        v.exp_rxf = rxf; v.exp_txe = txe; v.exp_fv = fv;
        v.chk_bus = cb; v.exp_bus = eb; v.chk_f2h = cf; v.exp_f2h = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                oe rd wr hv hd  fr wd            rxf txe fv  cb eb  cf ef
        vecs[0]  = mk(1, 1, 1, 1, 32'd1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 1, 32'd2, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 1, 32'd3, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 1, 1, 32'd4, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 0, 32'd0, 0, 32'h0,          0, 0, 0, 1, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 32'd0, 0, 32'h0,          0, 0, 0, 1, 2, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 32'd0, 0, 32'h0,          0, 0, 0, 1, 3, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 32'd0, 0, 32'h0,          0, 0, 0, 1, 4, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 32'd0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 0, 32'd0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 32'd0, 0, 32'hA5A5A5A5,   1, 0, 1, 0, 0, 1, 32'hA5A5A5A5);
        vecs[11] = mk(1, 1, 0, 0, 32'd0, 0, 32'h5A5A5A5A,   1, 0, 1, 0, 0, 1, 32'hA5A5A5A5);
        vecs[12] = mk(1, 1, 1, 0, 32'd0, 1, 32'h0,          1, 0, 1, 0, 0, 1, 32'h5A5A5A5A);
        vecs[13] = mk(1, 1, 1, 0, 32'd0, 1, 32'h0,          1, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 1, 1, 32'd7, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 1, 0, 32'd0, 0, 32'h0,          0, 0, 0, 1, 7, 0, 0);
        vecs[16] = mk(0, 0, 1, 1, 32'd8, 0, 32'h0,          0, 0, 0, 1, 8, 0, 0);
        vecs[17] = mk(1, 1, 1, 0, 32'd0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; rd_n = 1'b1; oe_n = 1'b1; wr_n = 1'b1;
        h2f_valid = 1'b0; h2f_data = '0; f2h_ready = 1'b0;
        tb_data = 32'h1234_5678; tb_be = 4'h3; tb_drv = 1'b1;
        tick(); tick(); tick();
        check("reset rxf_n", rxf_n, 1);
        check("reset txe_n", txe_n, 1);
        check("reset proto_err", proto_err, 0);
        check("reset h2f_ready", h2f_ready, 0);
        check("reset f2h_valid", f2h_valid, 0);
        // The responder must leave the bus alone while oe_n is high.
        check("bus released data", ft_data, 32'h1234_5678);
        check("bus released be", ft_be, 4'h3);
        tb_drv = 1'b0; tb_be = 4'hF;
        reset = 1'b0;
        tick();
        check("post-reset rxf_n", rxf_n, 1);
        check("post-reset txe_n", txe_n, 0);
        check("post-reset h2f_ready", h2f_ready, 1);
        check("post-reset proto_err", proto_err, 0);

`ifdef FT600_RESPONDER_THROTTLE_EN
        for (int i = 0; i < 8; i++) begin
            h2f_valid = 1'b1; h2f_data = 32'd100 + 32'(i);
            tick();
        end
        h2f_valid = 1'b0;
        oe_n = 1'b0;
        tick();
        check("thr head", ft_data, 32'd100);
        rd_n = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rd_n = 1'b1;
        check("thr rxf after burst", rxf_n, 1);
        check("thr txe after burst", txe_n, 1);
        check("thr head after burst", ft_data, 32'd104);
        for (int g = 0; g < 3; g++) begin
            tick();
            check($sformatf("thr rxf gap %0d", g), rxf_n, (g < 2) ? 1 : 0);
        end
        check("thr proto_err", proto_err, 0);
`else
        for (int i = 0; i < 18; i++) begin
            oe_n = vecs[i].oe_n; rd_n = vecs[i].rd_n; wr_n = vecs[i].wr_n;
            h2f_valid = vecs[i].hv; h2f_data = vecs[i].hd; f2h_ready = vecs[i].fr;
            tb_data = vecs[i].wd; tb_drv = !vecs[i].wr_n;
            tick();
            check($sformatf("v%0d rxf_n", i), rxf_n, vecs[i].exp_rxf);
            check($sformatf("v%0d txe_n", i), txe_n, vecs[i].exp_txe);
            check($sformatf("v%0d f2h_valid", i), f2h_valid, vecs[i].exp_fv);
            check($sformatf("v%0d proto_err", i), proto_err, 0);
            if (vecs[i].chk_bus) begin
                check($sformatf("v%0d ft_data", i), ft_data, vecs[i].exp_bus);
                check($sformatf("v%0d ft_be", i), ft_be, 4'hF);
            end
            if (vecs[i].chk_f2h) begin
                check($sformatf("v%0d f2h_data", i), f2h_data, vecs[i].exp_f2h);
                check($sformatf("v%0d f2h_be", i), f2h_be, 4'hF);
            end
        end
        h2f_valid = 1'b0; tb_drv = 1'b0;

        // wr_n and oe_n together: flagged, neither buffer moves (read buffer holds word 8).
        oe_n = 1'b0; wr_n = 1'b0;
        tick();
        check("conflict proto_err", proto_err, 1);
        check("conflict rxf_n", rxf_n, 0);
        check("conflict f2h_valid", f2h_valid, 0);
        oe_n = 1'b1; wr_n = 1'b1;
        tick();
        check("conflict head", dut.u_rd_fifo.count, 1);
        check("sticky proto_err", proto_err, 1);

        reset = 1'b1;
        tick(); tick();
        check("mid reset proto_err", proto_err, 0);
        check("mid reset rxf_n", rxf_n, 1);
        reset = 1'b0;
        tick();
        check("discard rxf_n", rxf_n, 1);
        check("discard txe_n", txe_n, 0);

        // Fill the write buffer, then strobe once more into a full buffer.
        f2h_ready = 1'b0; tb_drv = 1'b1; wr_n = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tb_data = 32'(i);
            tick();
        end
        check("full txe_n", txe_n, 1);
        check("full proto_err", proto_err, 0);
        check("full f2h_valid", f2h_valid, 1);
        tb_data = 32'hFFFF_FFFF;
        tick();
        check("overflow proto_err", proto_err, 1);
        check("overflow txe_n", txe_n, 1);
        wr_n = 1'b1; tb_drv = 1'b0; f2h_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            check($sformatf("drain word %0d", i), f2h_data, 32'(i));
            tick();
            if (i == 0) check("txe_n after first drain", txe_n, 0);
        end
        check("drained f2h_valid", f2h_valid, 0);
        f2h_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
